// File: rtl/odo_round_key_stage.sv
// -----------------------------------------------------------------------------
// odo_round_key_stage
//
// Registered round-key application stage of the Odo permutation core. It keeps
// a writable table of ROUNDS round keys and an internal round counter, and
// XORs the selected key into the low KBITS of every state word. Valid/ready
// handshake on both sides, one cycle latency, full throughput.
//
// Optional feature (macro ODO_RK_PARITY_EN): each key entry carries an even
// parity bit written with the data. The parity of the entry read on every
// accepted beat is checked, and a mismatch raises the sticky key_perr flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   kwr_en     key-table write strobe
//   kwr_addr   key-table write index (writes at >= ROUNDS are ignored)
//   kwr_data   key-table write data, KBITS per word
//   in_valid   input beat valid
//   in_ready   stage can accept an input beat
//   in_first   beat is round 0, restarts the round counter
//   in_state   input state, WORDS x WORD_W bits
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_state  keyed state
//   out_round  round index used for out_state
//   out_last   out_round is the final round (ROUNDS-1)
//   key_perr   sticky key parity error (ODO_RK_PARITY_EN only)
// -----------------------------------------------------------------------------
module odo_round_key_stage #(
    parameter int  WORDS  = 10,
    parameter int  WORD_W = 64,
    parameter int  KBITS  = 1,
    parameter int  ROUNDS = 84,
    localparam int ST_W   = WORDS * WORD_W,
    localparam int KEY_W  = WORDS * KBITS,
    localparam int RIDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              kwr_en,
    input  logic [RIDX_W-1:0] kwr_addr,
    input  logic [KEY_W-1:0]  kwr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [ST_W-1:0]   in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ST_W-1:0]   out_state,
    output logic [RIDX_W-1:0] out_round,
    output logic              out_last
`ifdef ODO_RK_PARITY_EN
    ,
    output logic              key_perr
`endif
);

`ifdef ODO_RK_PARITY_EN
    localparam int ENT_W = KEY_W + 1;
`else
    localparam int ENT_W = KEY_W;
`endif

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

    logic [ENT_W-1:0]  key_mem [ROUNDS];
    logic [ENT_W-1:0]  ent_rd;
    logic [ENT_W-1:0]  ent_wr;
    logic [KEY_W-1:0]  key_rd;
    logic              key_wr_ok;

    logic              accept;
    logic [RIDX_W-1:0] r_sel;
    logic              r_last;
    logic [ST_W-1:0]   keyed;

    logic              out_valid_q, out_valid_d;
    logic [ST_W-1:0]   out_state_q, out_state_d;
    logic [RIDX_W-1:0] out_round_q, out_round_d;
    logic              out_last_q,  out_last_d;
    logic [RIDX_W-1:0] rc_q, rc_d;

    // The output register frees up in the same cycle it is drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign r_sel  = in_first ? '0 : rc_q;
    assign r_last = (r_sel == LAST_IDX);

    // Asynchronous table read: a write landing on the same edge only takes
    // effect afterwards, so an accept sees the old entry.
    assign ent_rd = key_mem[r_sel];
    assign key_rd = ent_rd[KEY_W-1:0];

    assign key_wr_ok = kwr_en && (int'(kwr_addr) < ROUNDS);

`ifdef ODO_RK_PARITY_EN
    // Even parity: data plus parity bit XOR to zero.
    assign ent_wr = {^kwr_data, kwr_data};
`else
    assign ent_wr = kwr_data;
`endif

    // Key table has no reset; its contents are defined only by writes.
    always_ff @(posedge clk) begin
        if (key_wr_ok) begin
            key_mem[kwr_addr] <= ent_wr;
        end
    end

    always_comb begin
        keyed = in_state;
        for (int w = 0; w < WORDS; w++) begin
            keyed[w*WORD_W +: KBITS] = in_state[w*WORD_W +: KBITS] ^ key_rd[w*KBITS +: KBITS];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        rc_d        = rc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_state_d = keyed;
            out_round_d = r_sel;
            out_last_d  = r_last;
            rc_d        = r_last ? '0 : r_sel + RIDX_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            rc_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            rc_q        <= rc_d;
        end
    end

`ifdef ODO_RK_PARITY_EN
    logic perr_q, perr_d;

    assign perr_d = perr_q || (accept && (^ent_rd));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign key_perr = perr_q;
`endif

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_odo_round_key_stage.sv
// -----------------------------------------------------------------------------
// tb_odo_round_key_stage
//
// Self-checking bench for odo_round_key_stage with default parameters.
// Expected beats are produced by a transaction-level reference model (key
// array, round counter, FIFO of expected outputs) and compared whenever an
// output beat completes; directed steps cover the key application, round
// wrap, back-pressure, same-cycle key rewrite and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_odo_round_key_stage;
    localparam int WORDS  = 10;
    localparam int WORD_W = 64;
    localparam int KBITS  = 1;
    localparam int ROUNDS = 84;
    localparam int ST_W   = WORDS * WORD_W;
    localparam int KEY_W  = WORDS * KBITS;
    localparam int RIDX_W = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              kwr_en;
    logic [RIDX_W-1:0] kwr_addr;
    logic [KEY_W-1:0]  kwr_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic [ST_W-1:0]   in_state;
    logic              out_valid;
    logic              out_ready;
    logic [ST_W-1:0]   out_state;
    logic [RIDX_W-1:0] out_round;
    logic              out_last;
`ifdef ODO_RK_PARITY_EN
    logic              key_perr;
`endif

    odo_round_key_stage #(
        .WORDS (WORDS),
        .WORD_W(WORD_W),
        .KBITS (KBITS),
        .ROUNDS(ROUNDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .kwr_en   (kwr_en),
        .kwr_addr (kwr_addr),
        .kwr_data (kwr_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .in_state (in_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state),
        .out_round(out_round),
        .out_last (out_last)
`ifdef ODO_RK_PARITY_EN
        ,
        .key_perr (key_perr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ST_W-1:0] st;
        int              rnd;
        logic            last;
    } beat_t;

    int               total = 0;
    int               bad   = 0;
    beat_t            expq[$];
    logic [KEY_W-1:0] kmodel [ROUNDS];
    int               mrc = 0;
    logic             prev_stall = 1'b0;
    logic [ST_W-1:0]  prev_state;
    logic [RIDX_W-1:0] prev_round;

    task automatic check(input string tag, input logic [ST_W-1:0] obs, input logic [ST_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference key application, bit by bit: bit i of the state belongs to
    // word i/WORD_W; its position within the word selects a key bit if low.
    function automatic logic [ST_W-1:0] ref_key(input logic [ST_W-1:0] s, input logic [KEY_W-1:0] k);
        logic [ST_W-1:0] o;
        o = s;
        for (int i = 0; i < ST_W; i++) begin
            if ((i % WORD_W) < KBITS) begin
                o[i] = s[i] ^ k[(i / WORD_W) * KBITS + (i % WORD_W)];
            end
        end
        return o;
    endfunction

    function automatic logic [ST_W-1:0] rand_state();
        logic [ST_W-1:0] s;
        for (int i = 0; i < ST_W / 32; i++) begin
            s[i*32 +: 32] = $urandom;
        end
        return s;
    endfunction

    // One clock: observe at the falling edge, update the model, return 1ns
    // after the rising edge so the caller can drive the next inputs.
    task automatic tick();
        logic  acc;
        logic  done;
        logic  exp_busy;
        beat_t b;
        int    r;
        @(negedge clk);
        exp_busy = (expq.size() != 0);
        acc  = in_valid && in_ready;
        done = out_valid && out_ready;
        check("in_ready", ST_W'(in_ready), ST_W'(!exp_busy || out_ready));
        check("out_valid", ST_W'(out_valid), ST_W'(exp_busy));
        if (prev_stall) begin
            check("stall_state", out_state, prev_state);
            check("stall_round", ST_W'(out_round), ST_W'(prev_round));
        end
        if (done && exp_busy) begin
            b = expq.pop_front();
            check("beat_state", out_state, b.st);
            check("beat_round", ST_W'(out_round), ST_W'(b.rnd));
            check("beat_last", ST_W'(out_last), ST_W'(b.last));
        end
        prev_stall = out_valid && !out_ready;
        prev_state = out_state;
        prev_round = out_round;
        if (acc) begin
            r = in_first ? 0 : mrc;
            expq.push_back('{ref_key(in_state, kmodel[r]), r, (r == ROUNDS - 1)});
            mrc = (r == ROUNDS - 1) ? 0 : r + 1;
        end
        if (kwr_en && int'(kwr_addr) < ROUNDS) begin
            kmodel[kwr_addr] = kwr_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [ST_W-1:0]  c1;
        logic [ST_W-1:0]  st5;
        logic [KEY_W-1:0] old5;

        reset     = 1'b1;
        kwr_en    = 1'b0;
        kwr_addr  = '0;
        kwr_data  = '0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", ST_W'(out_valid), '0);
        check("rst_out_state", out_state, '0);
        check("rst_out_round", ST_W'(out_round), '0);
        check("rst_out_last", ST_W'(out_last), '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill the whole key table with random keys.
        for (int a = 0; a < ROUNDS; a++) begin
            kwr_en   = 1'b1;
            kwr_addr = RIDX_W'(a);
            kwr_data = KEY_W'($urandom);
            tick();
        end

        // Known keys for rounds 0 and 1, then an all-zero and all-ones beat.
        kwr_addr = 0; kwr_data = 10'h3FF; tick();
        kwr_addr = 1; kwr_data = 10'h001; tick();
        kwr_en   = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_state = '0;
        tick();
        c1 = '0;
        for (int w = 0; w < WORDS; w++) c1[w*WORD_W] = 1'b1;
        check("t1_beat1_state", out_state, c1);
        check("t1_beat1_round", ST_W'(out_round), '0);
        in_first = 1'b0; in_state = '1;
        tick();
        check("t1_beat2_state", out_state, {{(ST_W-1){1'b1}}, 1'b0});
        check("t1_beat2_round", ST_W'(out_round), ST_W'(1));

        // Rounds 0..4, then round 5 with a same-cycle rewrite of key[5].
        in_first = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_state = rand_state();
            tick();
            in_first = 1'b0;
        end
        old5     = kmodel[5];
        in_state = rand_state();
        st5      = in_state;
        kwr_en = 1'b1; kwr_addr = 5; kwr_data = 10'h155;
        tick();
        kwr_en = 1'b0;
        check("rbw_round", ST_W'(out_round), ST_W'(5));
        check("rbw_old_key", out_state, ref_key(st5, old5));

        // 85 beats from round 0: rounds run 0..83 then wrap to 0.
        for (int i = 0; i < 85; i++) begin
            in_first = (i == 0);
            in_state = rand_state();
            if (i == 5) st5 = in_state;
            tick();
            check("stream_round", ST_W'(out_round), ST_W'(i % ROUNDS));
            check("stream_last", ST_W'(out_last), ST_W'((i % ROUNDS) == ROUNDS - 1));
            if (i == 5) check("rbw_new_key", out_state, ref_key(st5, 10'h155));
        end
        in_first = 1'b0;

        // Back-pressure: two beats offered while out_ready is low.
        out_ready = 1'b0;
        in_state  = rand_state();
        tick();
        check("bp_in_ready_low", ST_W'(in_ready), '0);
        in_state = rand_state();
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Reach round counter 40 with an output pending, then reset.
        in_valid = 1'b1; in_first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_state = rand_state();
            tick();
            in_first = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_valid", ST_W'(out_valid), ST_W'(1));
        check("pre_rst_round", ST_W'(out_round), ST_W'(39));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", ST_W'(out_valid), '0);
        check("async_rst_round", ST_W'(out_round), '0);
        expq.delete();
        mrc        = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_first  = 1'b0;
        in_state  = rand_state();
        tick();
        check("post_rst_round", ST_W'(out_round), '0);
        in_valid = 1'b0;
        tick();

        // Random traffic, random key writes including out-of-range indices.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 15) == 0);
            in_state  = rand_state();
            out_ready = ($urandom_range(0, 3) != 0);
            kwr_en    = ($urandom_range(0, 3) == 0);
            kwr_addr  = RIDX_W'($urandom_range(0, 127));
            kwr_data  = KEY_W'($urandom);
            tick();
        end
        kwr_en    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

`ifdef ODO_RK_PARITY_EN
        check("perr_clean", ST_W'(key_perr), '0);
        dut.key_mem[7] = dut.key_mem[7] ^ 11'h001;
        kmodel[7]      = kmodel[7] ^ 10'h001;
        in_valid = 1'b1; in_first = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_state = rand_state();
            tick();
            in_first = 1'b0;
            if (i == 6) check("perr_before", ST_W'(key_perr), '0);
        end
        check("perr_set", ST_W'(key_perr), ST_W'(1));
        in_valid = 1'b0;
        tick();
        tick();
        check("perr_sticky", ST_W'(key_perr), ST_W'(1));
        reset = 1'b1;
        #1;
        check("perr_rst", ST_W'(key_perr), '0);
        expq.delete();
        mrc        = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
